// File: rtl/dac_run_sequencer.sv
// dac_run_sequencer: GPIO-programmed PRE/RUN/POST cycle sequencer; define DAC_SEQ_TRIG_COUNT_EN for trigger counters
module dac_run_sequencer #(
    parameter int CFG_W  = 32,
    parameter int GPIO_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [2:0]        state_o,
    output logic              run_en,
    output logic              run_first,
    output logic              run_last,
    output logic [CFG_W-1:0]  run_idx,
    output logic              busy,
    output logic              done_pulse,
`ifdef DAC_SEQ_TRIG_COUNT_EN
    output logic              trig_ignored,
    output logic [15:0]       trig_count,
    output logic [15:0]       ign_count
`else
    output logic              trig_ignored
`endif
);
    localparam logic [2:0] IDLE = 3'd0, PRE = 3'd1, RUN = 3'd2, POST = 3'd3, DONE = 3'd4;
    localparam logic [CFG_W-1:0] ONE = CFG_W'(1);

    logic [GPIO_W-1:0] s1, s2, hist, rise;
    logic [1:0]        arm;
    logic [CFG_W-1:0]  pre_cfg, run_cfg, post_cfg, pre_nx, run_nx, post_nx;
    logic [CFG_W-1:0]  pre_l, run_l, post_l, cnt, cnt_nx, later_run, later_post;
    logic [2:0]        state, state_nx;
    logic              pl_rst, start, ignore, in_phase, unused_rise;

    function automatic logic [2:0] first_phase(input logic [CFG_W-1:0] p, input logic [CFG_W-1:0] r,
                                               input logic [CFG_W-1:0] q);
        return (p != '0) ? PRE : (r != '0) ? RUN : (q != '0) ? POST : DONE;
    endfunction

    function automatic logic [CFG_W-1:0] first_count(input logic [CFG_W-1:0] p, input logic [CFG_W-1:0] r,
                                                     input logic [CFG_W-1:0] q);
        return (p != '0) ? p : (r != '0) ? r : q;
    endfunction

    // Edges are masked until the history register holds a real sample, so levels held across reset are not edges
    assign rise        = (arm == 2'd3) ? (s2 & ~hist) : '0;
    assign unused_rise = ^rise;
    assign pl_rst      = s2[5];
    assign pre_nx      = rise[9]  ? {pre_cfg[CFG_W-2:0],  s2[0]} : pre_cfg;
    assign run_nx      = rise[3]  ? {run_cfg[CFG_W-2:0],  s2[0]} : run_cfg;
    assign post_nx     = rise[10] ? {post_cfg[CFG_W-2:0], s2[0]} : post_cfg;
    assign start       = rise[6] && state == IDLE && !pl_rst;
    assign ignore      = rise[6] && state != IDLE && !pl_rst;
    assign in_phase    = state == PRE || state == RUN || state == POST;
    assign later_run   = (state == PRE) ? run_l : '0;
    assign later_post  = (state == POST) ? '0 : post_l;

    assign state_o    = state;
    assign run_en     = state == RUN;
    assign run_first  = run_en && run_idx == '0;
    assign run_last   = run_en && cnt == ONE;
    assign busy       = state != IDLE;
    assign done_pulse = state == DONE;

    // Next phase selection: a phase ends when its remaining count reaches one
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (start) begin
            state_nx = first_phase(pre_nx, run_nx, post_nx);
            cnt_nx   = first_count(pre_nx, run_nx, post_nx);
        end else if (state == DONE) begin
            state_nx = IDLE;
        end else if (in_phase && cnt == ONE) begin
            state_nx = first_phase('0, later_run, later_post);
            cnt_nx   = first_count('0, later_run, later_post);
        end else if (in_phase) begin
            cnt_nx = cnt - ONE;
        end
    end

    // Synchronizer, history register and post-reset edge arming
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1   <= '0;
            s2   <= '0;
            hist <= '0;
            arm  <= '0;
        end else begin
            s1   <= gpio_in;
            s2   <= s1;
            hist <= s2;
            arm  <= arm + {1'b0, arm != 2'd3};
        end
    end

    // Serial config registers; shifting is allowed in any state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_cfg  <= '0;
            run_cfg  <= '0;
            post_cfg <= '0;
        end else begin
            pre_cfg  <= pre_nx;
            run_cfg  <= run_nx;
            post_cfg <= post_nx;
        end
    end

    // Sequencer FSM with counts latched at trigger; pl_rst forces IDLE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            run_idx      <= '0;
            trig_ignored <= 1'b0;
            pre_l        <= '0;
            run_l        <= '0;
            post_l       <= '0;
        end else if (pl_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            run_idx      <= '0;
            trig_ignored <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            run_idx      <= (state == RUN && state_nx == RUN) ? run_idx + ONE : '0;
            trig_ignored <= ignore;
            if (start) begin
                pre_l  <= pre_nx;
                run_l  <= run_nx;
                post_l <= post_nx;
            end
        end
    end

`ifdef DAC_SEQ_TRIG_COUNT_EN
    // Saturating counts of accepted and ignored triggers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trig_count <= '0;
            ign_count  <= '0;
        end else if (pl_rst) begin
            trig_count <= '0;
            ign_count  <= '0;
        end else begin
            if (start && !(&trig_count)) trig_count <= trig_count + 16'd1;
            if (ignore && !(&ign_count)) ign_count <= ign_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dac_run_sequencer.sv
// tb_dac_run_sequencer: directed scenarios for dac_run_sequencer
module tb_dac_run_sequencer;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] gpio_in = '0;
    logic [2:0]  state_o;
    logic        run_en, run_first, run_last, busy, done_pulse, trig_ignored;
    logic [31:0] run_idx;
`ifdef DAC_SEQ_TRIG_COUNT_EN
    logic [15:0] trig_count, ign_count;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dac_run_sequencer #(.CFG_W(32), .GPIO_W(16)) dut (
        .clk(clk), .rstn(rstn), .gpio_in(gpio_in), .state_o(state_o), .run_en(run_en),
        .run_first(run_first), .run_last(run_last), .run_idx(run_idx), .busy(busy),
        .done_pulse(done_pulse),
`ifdef DAC_SEQ_TRIG_COUNT_EN
        .trig_ignored(trig_ignored), .trig_count(trig_count), .ign_count(ign_count)
`else
        .trig_ignored(trig_ignored)
`endif
    );

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        gpio_in = '0;
        step(2);
        rstn = 1'b1;
        step(5);
    endtask

    task automatic shift(input int b, input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            gpio_in[0] = v[i];
            gpio_in[b] = 1'b1;
            step(3);
            gpio_in[b] = 1'b0;
            step(3);
        end
    endtask

    task automatic fire();
        gpio_in[6] = 1'b1;
        step(3);
        gpio_in[6] = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({state_o, run_en, run_first, run_last, busy, done_pulse, trig_ignored, run_idx} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs state=%0d run_en=%b busy=%b idx=%0d expected all zero", state_o, run_en, busy, run_idx);
        end
    endtask

    task automatic test_basic();
        logic [2:0]  es [11] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
        logic [31:0] ei [11] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        do_reset();
        shift(9, 32'd2, 2);
        shift(3, 32'd4, 3);
        shift(10, 32'd3, 2);
        fire();
        for (int i = 0; i < 11; i++) begin
            n_cmp++;
            if (state_o !== es[i] || run_idx !== ei[i] || run_first !== (i == 2) || run_last !== (i == 5) ||
                done_pulse !== (i == 9) || busy !== (i != 10)) begin
                n_bad++;
                $display("FAIL basic cyc%0d state=%0d idx=%0d first=%b last=%b done=%b busy=%b expected state=%0d idx=%0d",
                         i, state_o, run_idx, run_first, run_last, done_pulse, busy, es[i], ei[i]);
            end
            step();
        end
    endtask

    task automatic test_run1();
        logic [2:0] es [3] = '{3'd2, 3'd4, 3'd0};
        do_reset();
        shift(3, 32'd1, 1);
        fire();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (state_o !== es[i] || run_first !== (i == 0) || run_last !== (i == 0) || run_idx !== 32'd0) begin
                n_bad++;
                $display("FAIL run1 cyc%0d state=%0d first=%b last=%b idx=%0d expected state=%0d", i, state_o, run_first, run_last, run_idx, es[i]);
            end
            step();
        end
    endtask

    task automatic test_zero_latency();
        int runs = 0;
        do_reset();
        gpio_in[6] = 1'b1;
        step();
        n_cmp++;
        if (state_o !== 3'd0) begin n_bad++; $display("FAIL lat_k state=%0d expected 0", state_o); end
        step();
        n_cmp++;
        if (state_o !== 3'd0) begin n_bad++; $display("FAIL lat_k1 state=%0d expected 0", state_o); end
        step();
        gpio_in[6] = 1'b0;
        n_cmp++;
        if (state_o !== 3'd4 || done_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_done state=%0d done=%b expected 4 1", state_o, done_pulse);
        end
        runs += run_en;
        step();
        runs += run_en;
        n_cmp++;
        if (state_o !== 3'd0 || done_pulse !== 1'b0 || runs != 0) begin
            n_bad++;
            $display("FAIL zero_idle state=%0d done=%b runs=%0d expected 0 0 0", state_o, done_pulse, runs);
        end
    endtask

    task automatic test_ignore();
        int runs = 0, igns = 0, dones = 0;
        do_reset();
        shift(3, 32'd10, 4);
        fire();
        for (int i = 0; i < 15; i++) begin
            runs += run_en;
            igns += trig_ignored;
            dones += done_pulse;
            if (i == 9) begin
                n_cmp++;
                if (run_idx !== 32'd9 || run_last !== 1'b1) begin
                    n_bad++;
                    $display("FAIL ign_last idx=%0d last=%b expected 9 1", run_idx, run_last);
                end
            end
            if (i == 3) gpio_in[6] = 1'b1;
            if (i == 8) gpio_in[6] = 1'b0;
            step();
        end
        n_cmp++;
        if (runs != 10 || igns != 1 || dones != 1 || state_o !== 3'd0) begin
            n_bad++;
            $display("FAIL ignore runs=%0d igns=%0d dones=%0d state=%0d expected 10 1 1 0", runs, igns, dones, state_o);
        end
`ifdef DAC_SEQ_TRIG_COUNT_EN
        n_cmp++;
        if (trig_count !== 16'd1 || ign_count !== 16'd1) begin
            n_bad++;
            $display("FAIL counters trig=%0d ign=%0d expected 1 1", trig_count, ign_count);
        end
`endif
    endtask

    task automatic test_plrst();
        int dones = 0;
        do_reset();
        shift(3, 32'd2, 2);
        shift(10, 32'd8, 4);
        fire();
        for (int i = 0; i < 15; i++) begin
            dones += done_pulse;
            if (i == 5 || i == 6) begin
                n_cmp++;
                if (state_o !== ((i == 5) ? 3'd3 : 3'd0)) begin
                    n_bad++;
                    $display("FAIL plrst cyc%0d state=%0d expected %0d", i, state_o, (i == 5) ? 3 : 0);
                end
            end
`ifdef DAC_SEQ_TRIG_COUNT_EN
            if (i == 9) begin
                n_cmp++;
                if (trig_count !== 16'd0) begin n_bad++; $display("FAIL plrst_cnt trig=%0d expected 0", trig_count); end
            end
`endif
            if (i == 3) gpio_in[5] = 1'b1;
            if (i == 8) gpio_in[5] = 1'b0;
            step();
        end
        n_cmp++;
        if (dones != 0) begin n_bad++; $display("FAIL plrst_done dones=%0d expected 0", dones); end
        fire();
        n_cmp++;
        if (state_o !== 3'd2 || run_first !== 1'b1) begin
            n_bad++;
            $display("FAIL retrig state=%0d first=%b expected 2 1", state_o, run_first);
        end
        step(2);
        n_cmp++;
        if (state_o !== 3'd3) begin n_bad++; $display("FAIL retrig_post state=%0d expected 3", state_o); end
    endtask

    task automatic test_coincident();
        do_reset();
        gpio_in[0] = 1'b1;
        gpio_in[3] = 1'b1;
        gpio_in[6] = 1'b1;
        step(3);
        gpio_in = '0;
        n_cmp++;
        if (state_o !== 3'd2 || run_last !== 1'b1) begin
            n_bad++;
            $display("FAIL coincident state=%0d last=%b expected 2 1", state_o, run_last);
        end
    endtask

    task automatic test_rstn();
        int busys = 0, dones = 0;
        do_reset();
        shift(3, 32'd6, 3);
        fire();
        step(2);
        gpio_in[6] = 1'b1;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({state_o, run_en, run_first, run_last, busy, done_pulse, trig_ignored, run_idx} !== '0) begin
            n_bad++;
            $display("FAIL rstn_async state=%0d run_en=%b busy=%b idx=%0d expected all zero", state_o, run_en, busy, run_idx);
        end
        step(3);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            busys += busy;
            dones += done_pulse;
        end
        n_cmp++;
        if (busys != 0 || dones != 0 || state_o !== 3'd0) begin
            n_bad++;
            $display("FAIL held_trig busys=%0d dones=%0d state=%0d expected 0 0 0", busys, dones, state_o);
        end
        gpio_in[6] = 1'b0;
        step(3);
        fire();
        n_cmp++;
        if (state_o !== 3'd4) begin n_bad++; $display("FAIL rstn_retrig state=%0d expected 4", state_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_run1();
        test_zero_latency();
        test_ignore();
        test_plrst();
        test_coincident();
        test_rstn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dac_run_sequencer.md
DAC_RUN_SEQUENCER -- requirements
Module: dac_run_sequencer

Interface
REQ-001 SHALL have parameter CFG_W, default 32, meaning width of the pre-delay, run-cycle and post-delay counts.
REQ-002 SHALL have parameter GPIO_W, default 16, meaning width of the PS GPIO control bus.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is in this domain.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port gpio_in, input, GPIO_W bits: PS GPIO bus, asynchronous to clk. Bits used: 0 sdata, 3 cycle_count_clk, 5 pl_rst, 6 trigger_line, 9 pre_delay_cycle_clk, 10 post_delay_cycle_clk.
REQ-006 SHALL have port state_o, output, 3 bits: FSM state, encoded IDLE=0, PRE=1, RUN=2, POST=3, DONE=4.
REQ-007 SHALL have port run_en, output, 1 bit: high on every cycle in the RUN state.
REQ-008 SHALL have port run_first, output, 1 bit: high on the first RUN cycle.
REQ-009 SHALL have port run_last, output, 1 bit: high on the last RUN cycle.
REQ-010 SHALL have port run_idx, output, CFG_W bits: index of the current RUN cycle, counting from 0.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port done_pulse, output, 1 bit: high for exactly the one DONE cycle.
REQ-013 SHALL have port trig_ignored, output, 1 bit: one-cycle pulse when a trigger edge arrives while busy.

Function
REQ-014 SHALL pass gpio_in through a 2-flop synchronizer and then a third (history) register; a rising edge on a bit is sync2 high and history low.
REQ-015 SHALL, on a rising edge of bit 9, shift sdata into the pre-delay register as its new LSB (the register shifts left by one).
REQ-016 SHALL, on a rising edge of bit 3, shift sdata into the run-count register in the same way as REQ-015.
REQ-017 SHALL, on a rising edge of bit 10, shift sdata into the post-delay register in the same way as REQ-015.
REQ-018 SHALL accept shifts in any FSM state; the RUN/PRE/POST cycles in progress are unaffected because counts are latched at trigger.
REQ-019 SHALL, on a trigger edge in IDLE, latch all three counts and go to the first non-zero phase in the order PRE, RUN, POST; if all three counts are zero, go to DONE.
REQ-020 SHALL keep PRE for exactly pre-delay cycles, RUN for exactly run-count cycles and POST for exactly post-delay cycles, skipping any phase whose count is zero.
REQ-021 SHALL keep DONE for 1 cycle, then return to IDLE.
REQ-022 SHALL drive run_idx to 0 at RUN entry and increment it each RUN cycle; run_idx is 0 outside RUN.
REQ-023 SHALL assert run_first and run_last together in the single RUN cycle when the run count is 1.
REQ-024 SHALL treat the count arithmetic as unsigned CFG_W bits; the maximum count, 2^CFG_W-1, is legal and nothing wraps.
REQ-025 SHALL, when gpio_in changes before clock edge k, have state_o leave IDLE at edge k+2, i.e. 3 edges of latency.
REQ-026 SHALL ignore a trigger edge while busy and pulse trig_ignored instead; the sequence continues unchanged.
REQ-027 SHALL, while synchronized pl_rst (bit 5) is high, hold the FSM in IDLE and clear the counters and pulse outputs; config registers are retained.
REQ-028 SHALL give pl_rst priority when pl_rst and a trigger edge occur in the same cycle; the trigger is lost.
REQ-029 SHALL apply a shift edge that coincides with a trigger edge before the latch; the latch captures the updated value.

Reset
REQ-030 SHALL, while rstn is low, clear synchronizers, history, config registers, latched counts and the FSM (IDLE), independent of clk.
REQ-031 SHALL hold all outputs at 0 in reset, including state_o=0.
REQ-032 SHALL abort a sequence when rstn is asserted mid-sequence, with no done_pulse; after release the block is in IDLE with zeroed config.
REQ-033 SHALL not let a trigger_line held high across rstn release start a run; only a 0->1 transition after reset is an edge.

Configuration
REQ-034 SHALL, with macro DAC_SEQ_TRIG_COUNT_EN defined, add outputs trig_count[15:0] (accepted triggers) and ign_count[15:0] (ignored triggers), both saturating at 0xFFFF.
REQ-035 SHALL clear trig_count and ign_count on rstn, and also while pl_rst is high.
REQ-036 SHALL omit those ports and counters when DAC_SEQ_TRIG_COUNT_EN is undefined; all other behaviour is identical.

Verification
REQ-037 SHALL cover: shift pre=2, run=4, post=3, then trigger -> PRE 2 cycles, RUN 4 cycles with run_idx 0..3, first at idx 0, last at idx 3, POST 3 cycles, done_pulse 1 cycle, IDLE.
REQ-038 SHALL cover: pre=0, run=1, post=0, trigger -> direct IDLE->RUN, one cycle with run_first=run_last=1, then DONE.
REQ-039 SHALL cover: all counts 0, trigger -> IDLE->DONE->IDLE, done_pulse=1, run_en never high.
REQ-040 SHALL cover: second trigger during RUN of length 10 -> trig_ignored 1 pulse, RUN still exactly 10 cycles; with macro, trig_count=1, ign_count=1.
REQ-041 SHALL cover: pl_rst high during POST -> IDLE within 3 cycles, no done_pulse; retrigger reuses retained counts.
REQ-042 SHALL cover: rstn low mid-RUN, trigger held high through release -> all outputs 0, no new run until trigger 0->1.
